// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises deassertion of the asynchronous system reset to
// rsync_clk and releases NUM_DOMAINS active-low resets one at a time,
// GAP_CYCLES apart. test_mode_in bypasses the sequence so every output follows rst_n.
// Optional feature macro: RSEQ_SOFT_RESET_EN adds the soft-reset synchroniser,
// its edge detector and the SOFT state. Without it, soft_rst_in is ignored.
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_DOMAINS = 3,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned SOFT_HOLD   = 8
) (
    input  logic                   rsync_clk,
    input  logic                   rst_n,
    input  logic                   test_mode_in,
    input  logic                   soft_rst_in,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   ready_out
);

    localparam int unsigned MASK_W = NUM_DOMAINS;
    localparam int unsigned IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
`ifdef RSEQ_SOFT_RESET_EN
    localparam logic [1:0] ST_SOFT    = 2'd3;
`endif

    logic [SYNC_STAGES-1:0] rsync_q;
    logic                   sync_rst_n;

    logic [1:0]        state_q, state_d;
    logic [MASK_W-1:0] mask_q,  mask_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              ready_q, ready_d;

    // Reset synchroniser: asynchronous assertion, deassertion shifted in from a constant 1.
    always_ff @(posedge rsync_clk or negedge rst_n) begin
        if (!rst_n) begin
            rsync_q <= '0;
        end else begin
            rsync_q <= {rsync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = rsync_q[SYNC_STAGES-1];

`ifdef RSEQ_SOFT_RESET_EN
    logic [SYNC_STAGES-1:0] ssync_q;
    logic                   soft_prev_q;
    logic                   soft_evt;

    // Soft-request synchroniser and registered rising-edge detector; a held level yields one event.
    always_ff @(posedge rsync_clk or negedge rst_n) begin
        if (!rst_n) begin
            ssync_q     <= '0;
            soft_prev_q <= 1'b0;
            soft_evt    <= 1'b0;
        end else begin
            ssync_q     <= {ssync_q[SYNC_STAGES-2:0], soft_rst_in};
            soft_prev_q <= ssync_q[SYNC_STAGES-1];
            soft_evt    <= ssync_q[SYNC_STAGES-1] & ~soft_prev_q;
        end
    end
`else
    // The soft-reset path is not built; the request input and hold length go nowhere.
    logic unused_soft;
    assign unused_soft = soft_rst_in ^ (SOFT_HOLD == 0);
`endif

    // FSM state and sequencing registers.
    always_ff @(posedge rsync_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            mask_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: staggered release, completion, and the optional soft hold.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            ST_HOLD: begin
                if (sync_rst_n) begin
                    state_d = ST_RELEASE;
                    mask_d  = MASK_W'(1);
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        mask_d = mask_q | (MASK_W'(1) << (idx_q + IDX_W'(1)));
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
`ifdef RSEQ_SOFT_RESET_EN
                if (soft_evt) begin
                    state_d = ST_SOFT;
                    mask_d  = '0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
`else
                state_d = ST_RUN;
`endif
            end
`ifdef RSEQ_SOFT_RESET_EN
            ST_SOFT: begin
                if (cnt_q == CNT_W'(SOFT_HOLD - 1)) begin
                    state_d = ST_RELEASE;
                    mask_d  = MASK_W'(1);
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_HOLD;
                mask_d  = '0;
                idx_d   = '0;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Test-mode bypass; in functional mode the outputs come straight from flops.
    assign rst_n_out = test_mode_in ? {NUM_DOMAINS{rst_n}} : mask_q;
    assign ready_out = test_mode_in ? rst_n : ready_q;

endmodule
